// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB master state encoding and default bus widths
package apb_pkg;

    localparam int APB_ADDR_W = 5;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB master with wait states, slave error and timeout
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_t       state;
    apb_state_t       state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    assign cmd_ready   = (state == IDLE);
    assign timeout_hit = (state == ACCESS) && !pready && (wait_cnt == CNT_LAST);

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (pready || timeout_hit) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus and response outputs are flops loaded from the next state so they change on the same edge as state.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            psel      <= (state_next == SETUP) || (state_next == ACCESS);
            penable   <= (state_next == ACCESS);
            rsp_valid <= (state_next == RESP);

            if (state == IDLE && cmd_valid) begin
                pwrite   <= cmd_write;
                paddr    <= cmd_addr;
                pwdata   <= cmd_wdata;
                wait_cnt <= '0;
            end else if (state == ACCESS && !pready && wait_cnt != CNT_LAST) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (state == ACCESS) begin
                if (pready) begin
                    rsp_rdata   <= pwrite ? '0 : prdata;
                    rsp_err     <= pslverr;
                    rsp_timeout <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed vector bench for apb_master
module tb_apb_master;

    logic        pclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int checks = 0;
    int passed = 0;

    always #5 pclk = ~pclk;

    apb_master #(.ADDR_W(5), .DATA_W(32), .TIMEOUT(16)) dut (
        .pclk(pclk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        logic        write;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] sdata;
        int          waits;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_lat;
        int          exp_pen;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Called just after a negedge with the master idle; returns just after a negedge, idle again.
    task automatic run_vec(input vec_t v, input string tag);
        int cyc = 0;
        int acc = 0;
        int npsel = 0;
        int npen = 0;
        int bad = 0;
        bit done = 0;
        rsp_ready = 1'b0;
        pready    = 1'b1;
        pslverr   = 1'b1;
        prdata    = 32'hBAD0_BAD0;
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        cmd_write = ~v.write;
        while (!done && cyc < 60) begin
            @(negedge pclk);
            cyc++;
            if (psel) begin
                npsel++;
                if (paddr !== v.addr || pwrite !== v.write || (v.write && pwdata !== v.wdata)) bad++;
            end
            if (penable) npen++;
            if (psel && penable) begin
                acc++;
                pready  = (acc > v.waits);
                pslverr = pready & v.slverr;
                prdata  = v.sdata;
            end else begin
                pready  = 1'b1;
                pslverr = 1'b1;
                prdata  = 32'hBAD0_BAD0;
            end
            if (rsp_valid) done = 1;
        end
        chk({tag, "_rsp_seen"}, done, 1);
        chk({tag, "_latency"}, cyc, v.exp_lat);
        chk({tag, "_penable_cycles"}, npen, v.exp_pen);
        chk({tag, "_psel_cycles"}, npsel, v.exp_pen + 1);
        chk({tag, "_bus_stable"}, bad, 0);
        chk({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, "_err_to"}, {rsp_err, rsp_timeout}, {v.exp_err, v.exp_to});
        chk({tag, "_resp_psel"}, {psel, penable, cmd_ready}, 3'b000);
        rsp_ready = 1'b1;
        @(posedge pclk);
        #1 rsp_ready = 1'b0;
        @(negedge pclk);
        chk({tag, "_back_idle"}, {cmd_ready, rsp_valid, psel}, 3'b100);
    endtask

    initial begin
        //           wr    addr   wdata         sdata         wt   serr  exp_rdata     err   to   lat pen
        vecs[0] = '{1'b1, 5'h10, 32'hDEADBEEF, 32'h0,        0,   1'b0, 32'h0,        1'b0, 1'b0, 3,  1};
        vecs[1] = '{1'b0, 5'h1C, 32'h0,        32'h00216948, 0,   1'b0, 32'h00216948, 1'b0, 1'b0, 3,  1};
        vecs[2] = '{1'b1, 5'h04, 32'h12345678, 32'hFFFF0000, 3,   1'b0, 32'h0,        1'b0, 1'b0, 6,  4};
        vecs[3] = '{1'b0, 5'h08, 32'h0,        32'h0000A5A5, 3,   1'b0, 32'h0000A5A5, 1'b0, 1'b0, 6,  4};
        vecs[4] = '{1'b0, 5'h0C, 32'h0,        32'hCAFEF00D, 0,   1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 3,  1};
        vecs[5] = '{1'b1, 5'h14, 32'h0BADF00D, 32'h77777777, 2,   1'b1, 32'h0,        1'b1, 1'b0, 5,  3};
        vecs[6] = '{1'b0, 5'h18, 32'h0,        32'h99999999, 255, 1'b0, 32'h0,        1'b1, 1'b1, 18, 16};
        vecs[7] = '{1'b0, 5'h1F, 32'h0,        32'h13579BDF, 15,  1'b0, 32'h13579BDF, 1'b0, 1'b0, 18, 16};

        @(negedge pclk);
        @(negedge pclk);
        chk("reset_ctrl", {cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout}, 7'b1000000);
        chk("reset_data", {paddr, pwdata, rsp_rdata}, 69'h0);
        reset_n = 1'b1;
        @(negedge pclk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Response backpressure with a second command waiting
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h11223344;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h02; cmd_wdata = 32'h0;
        @(posedge pclk);
        #1 cmd_write = 1'b1; cmd_addr = 5'h03; cmd_wdata = 32'h55;
        @(negedge pclk);
        chk("bp_setup", {psel, penable, pwrite, paddr}, {3'b100, 5'h02});
        @(negedge pclk);
        chk("bp_access", {psel, penable, pwrite, paddr}, {3'b110, 5'h02});
        @(negedge pclk);
        chk("bp_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h11223344});
        begin
            int bad = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge pclk);
                if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, cmd_ready, psel} !== {3'b100, 32'h11223344, 2'b00}) bad++;
            end
            chk("bp_hold", bad, 0);
        end
        rsp_ready = 1'b1;
        @(posedge pclk);
        #1 rsp_ready = 1'b0;
        @(negedge pclk);
        chk("bp_after_hs", {cmd_ready, psel, rsp_valid}, 3'b100);
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        @(negedge pclk);
        chk("bp_second_setup", {psel, penable, pwrite, paddr, pwdata}, {3'b101, 5'h03, 32'h55});
        @(negedge pclk);
        chk("bp_second_access", {psel, penable}, 2'b11);
        @(negedge pclk);
        chk("bp_second_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h0});
        rsp_ready = 1'b1;
        @(posedge pclk);
        #1 rsp_ready = 1'b0;
        @(negedge pclk);

        // Asynchronous reset during a wait state
        pready = 1'b0; pslverr = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h05;
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        @(negedge pclk);
        chk("rst_pre", {psel, penable}, 2'b11);
        #1 reset_n = 1'b0;
        #1 chk("rst_drop", {psel, penable, rsp_valid, cmd_ready}, 4'b0001);
        @(negedge pclk);
        reset_n = 1'b1;
        @(negedge pclk);
        chk("rst_idle", {cmd_ready, psel, rsp_valid}, 3'b100);
        run_vec(vecs[1], "post_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
